// File: rtl/btb_assoc_lru_if.sv
// Predict/resolve/flush bus for the set-associative BTB.
// The master side is the front end; the slave side is the BTB.
interface btb_assoc_lru_if #(
   parameter int W = 32
) ();
   logic         EN;
   logic         flush;
   logic         predict;
   logic [W-1:0] pred_pc;
   logic         resolve;
   logic [W-1:0] res_pc;
   logic         res_taken;
   logic [W-1:0] res_target;
   logic         HIT;
   logic [W-1:0] TARGET;
   logic         pred_taken;
   logic         out_valid;

   modport master (
      output EN, flush, predict, pred_pc, resolve, res_pc, res_taken, res_target,
      input  HIT, TARGET, pred_taken, out_valid
   );

   modport slave (
      input  EN, flush, predict, pred_pc, resolve, res_pc, res_taken, res_target,
      output HIT, TARGET, pred_taken, out_valid
   );
endinterface

// File: rtl/btb_assoc_lru.sv
// Set-associative branch target buffer with 2-bit direction counters,
// true-LRU replacement, fall-through target on miss and synchronous flush.
module btb_assoc_lru #(
   parameter int W      = 32,
   parameter int W_IND  = 4,
   parameter int WAYS   = 4,
   parameter int OFFSET = 2,
   parameter int CTR_W  = 2
) (
   input logic            clk,
   input logic            rst,
   btb_assoc_lru_if.slave bus
);
   localparam int SETS = 1 << W_IND;
   localparam int AW   = $clog2(WAYS);
   localparam int TW   = W - OFFSET - W_IND;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

   logic             valid_q  [SETS][WAYS];
   logic [TW-1:0]    tag_q    [SETS][WAYS];
   logic [W-1:0]     target_q [SETS][WAYS];
   logic [CTR_W-1:0] ctr_q    [SETS][WAYS];
   logic [AW-1:0]    age_q    [SETS][WAYS];

   logic             hit_q, taken_q, ov_q;
   logic [W-1:0]     tgt_q;

   logic [W_IND-1:0] p_idx, r_idx;
   logic [TW-1:0]    p_tag, r_tag;
   logic             p_hit, r_hit, inv_found;
   logic [AW-1:0]    p_way, r_way, victim, r_sel;
   logic             do_pred, do_res, res_upd, pred_promote;
   logic             unused_low;

   assign p_idx = bus.pred_pc[OFFSET+W_IND-1:OFFSET];
   assign p_tag = bus.pred_pc[W-1:OFFSET+W_IND];
   assign r_idx = bus.res_pc[OFFSET+W_IND-1:OFFSET];
   assign r_tag = bus.res_pc[W-1:OFFSET+W_IND];
   assign unused_low = ^bus.res_pc[OFFSET-1:0];

   always_comb begin
      p_hit     = 1'b0;
      p_way     = '0;
      r_hit     = 1'b0;
      r_way     = '0;
      inv_found = 1'b0;
      victim    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!p_hit && valid_q[p_idx][w] && tag_q[p_idx][w] == p_tag) begin
            p_hit = 1'b1;
            p_way = AW'(w);
         end
         if (!r_hit && valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag) begin
            r_hit = 1'b1;
            r_way = AW'(w);
         end
         if (!inv_found && !valid_q[r_idx][w]) begin
            inv_found = 1'b1;
            victim    = AW'(w);
         end
      end
      // Full set: fall back to the least recently used way.
      if (!inv_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[r_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
         end
      end
   end

   always_comb begin
      do_pred      = bus.EN & bus.predict;
      do_res       = bus.EN & bus.resolve & ~bus.flush;
      res_upd      = do_res & (r_hit | bus.res_taken);
      r_sel        = r_hit ? r_way : victim;
      pred_promote = do_pred & p_hit & ~bus.flush & ~(res_upd && r_idx == p_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               ctr_q[s][w]    <= '0;
               age_q[s][w]    <= AW'(w);
            end
         end
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               age_q[s][w]   <= AW'(w);
            end
         end
      end else begin
         // Predict and resolve promotions never touch the same set together.
         if (pred_promote) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == p_way)
                  age_q[p_idx][w] <= '0;
               else if (age_q[p_idx][w] < age_q[p_idx][p_way])
                  age_q[p_idx][w] <= age_q[p_idx][w] + AW'(1);
            end
         end
         if (res_upd) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == r_sel)
                  age_q[r_idx][w] <= '0;
               else if (age_q[r_idx][w] < age_q[r_idx][r_sel])
                  age_q[r_idx][w] <= age_q[r_idx][w] + AW'(1);
            end
            if (r_hit) begin
               if (bus.res_taken) begin
                  target_q[r_idx][r_sel] <= bus.res_target;
                  if (ctr_q[r_idx][r_sel] != CTR_MAX)
                     ctr_q[r_idx][r_sel] <= ctr_q[r_idx][r_sel] + CTR_W'(1);
               end else if (ctr_q[r_idx][r_sel] != '0) begin
                  ctr_q[r_idx][r_sel] <= ctr_q[r_idx][r_sel] - CTR_W'(1);
               end
            end else begin
               valid_q[r_idx][r_sel]  <= 1'b1;
               tag_q[r_idx][r_sel]    <= r_tag;
               target_q[r_idx][r_sel] <= bus.res_target;
               ctr_q[r_idx][r_sel]    <= CTR_WEAK;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ov_q    <= 1'b0;
         hit_q   <= 1'b0;
         tgt_q   <= '0;
         taken_q <= 1'b0;
      end else if (do_pred) begin
         ov_q    <= 1'b1;
         hit_q   <= p_hit;
         tgt_q   <= p_hit ? target_q[p_idx][p_way] : bus.pred_pc + W'(1 << OFFSET);
         taken_q <= p_hit & ctr_q[p_idx][p_way][CTR_W-1];
      end else begin
         ov_q    <= 1'b0;
      end
   end

   assign bus.out_valid  = ov_q;
   assign bus.HIT        = hit_q;
   assign bus.TARGET     = tgt_q;
   assign bus.pred_taken = taken_q;
endmodule

// File: tb/tb_btb_assoc_lru.sv
// Scoreboard bench for btb_assoc_lru: directed predict/resolve/flush/reset
// vectors push hand-computed lookups; a negedge monitor pops and compares.
module tb_btb_assoc_lru;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   btb_assoc_lru_if #(.W(W)) bus ();

   btb_assoc_lru #(.W(W), .W_IND(4), .WAYS(4), .OFFSET(2), .CTR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [W-1:0] pc;
      logic         hit;
      logic [W-1:0] tgt;
      logic         tk;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && bus.out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected no lookup pending");
         end else begin
            e = q.pop_front();
            chk($sformatf("hit pc=%h", e.pc), W'(bus.HIT), W'(e.hit));
            chk($sformatf("target pc=%h", e.pc), bus.TARGET, e.tgt);
            chk($sformatf("taken pc=%h", e.pc), W'(bus.pred_taken), W'(e.tk));
         end
      end
   end

   task automatic pred(input logic [W-1:0] pc, input logic h, input logic [W-1:0] t,
                       input logic tk);
      bus.predict = 1'b1;
      bus.pred_pc = pc;
      q.push_back({pc, h, t, tk});
      @(posedge clk);
      #1 bus.predict = 1'b0;
   endtask

   task automatic res(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt);
      bus.resolve    = 1'b1;
      bus.res_pc     = pc;
      bus.res_taken  = tk;
      bus.res_target = tgt;
      @(posedge clk);
      #1 bus.resolve = 1'b0;
   endtask

   task automatic both(input logic [W-1:0] ppc, input logic h, input logic [W-1:0] t,
                       input logic tk, input logic [W-1:0] rpc, input logic rtk,
                       input logic [W-1:0] rtgt, input logic fl);
      bus.predict    = 1'b1;
      bus.pred_pc    = ppc;
      bus.resolve    = 1'b1;
      bus.res_pc     = rpc;
      bus.res_taken  = rtk;
      bus.res_target = rtgt;
      bus.flush      = fl;
      q.push_back({ppc, h, t, tk});
      @(posedge clk);
      #1;
      bus.predict = 1'b0;
      bus.resolve = 1'b0;
      bus.flush   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.EN = 1'b1;   bus.flush = 1'b0;   bus.predict = 1'b0;  bus.pred_pc = '0;
      bus.resolve = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0; bus.res_target = '0;
      #1 rst = 1'b0;
      #2;
      chk("reset_out_valid", W'(bus.out_valid), '0);
      chk("reset_hit", W'(bus.HIT), '0);
      chk("reset_target", bus.TARGET, '0);
      chk("reset_taken", W'(bus.pred_taken), '0);
      #9 rst = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss, then idle drops out_valid
      pred(32'h120, 1'b0, 32'h124, 1'b0);
      @(posedge clk);
      #1 chk("idle_out_valid", W'(bus.out_valid), '0);

      // Fill set 8
      res(32'h120, 1'b1, 32'hAAAAAAAA);
      res(32'h220, 1'b1, 32'hBBBBBBBB);
      res(32'h320, 1'b1, 32'hCCCCCCCC);
      res(32'h420, 1'b1, 32'hDDDDDDDD);
      pred(32'h120, 1'b1, 32'hAAAAAAAA, 1'b1);
      pred(32'h220, 1'b1, 32'hBBBBBBBB, 1'b1);
      pred(32'h320, 1'b1, 32'hCCCCCCCC, 1'b1);
      pred(32'h420, 1'b1, 32'hDDDDDDDD, 1'b1);

      // LRU eviction of 0x120
      res(32'h520, 1'b1, 32'hEEEEEEEE);
      pred(32'h120, 1'b0, 32'h124, 1'b0);
      pred(32'h520, 1'b1, 32'hEEEEEEEE, 1'b1);

      // Direction counter on 0x220: down to 0, hold at 0, up to 3, hold, back to 2
      res(32'h220, 1'b0, 32'h0);
      res(32'h220, 1'b0, 32'h0);
      pred(32'h220, 1'b1, 32'hBBBBBBBB, 1'b0);
      res(32'h220, 1'b0, 32'h0);
      pred(32'h220, 1'b1, 32'hBBBBBBBB, 1'b0);
      for (int i = 0; i < 4; i++) res(32'h220, 1'b1, 32'hBBBBBBBB);
      pred(32'h220, 1'b1, 32'hBBBBBBBB, 1'b1);
      res(32'h220, 1'b0, 32'h0);
      pred(32'h220, 1'b1, 32'hBBBBBBBB, 1'b1);

      // Read-before-write on same-cycle predict/resolve; LRU way (0x320) is the victim
      both(32'h620, 1'b0, 32'h624, 1'b0, 32'h620, 1'b1, 32'h12345678, 1'b0);
      pred(32'h620, 1'b1, 32'h12345678, 1'b1);
      pred(32'h320, 1'b0, 32'h324, 1'b0);
      res(32'h720, 1'b0, 32'h77777777);
      pred(32'h720, 1'b0, 32'h724, 1'b0);

      // Flush with same-cycle predict (pre-flush view) and resolve (dropped)
      both(32'h220, 1'b1, 32'hBBBBBBBB, 1'b1, 32'h820, 1'b1, 32'h88888888, 1'b1);
      pred(32'h820, 1'b0, 32'h824, 1'b0);
      pred(32'h520, 1'b0, 32'h524, 1'b0);

      // EN=0 blocks both the lookup and the write
      bus.EN = 1'b0;
      bus.predict = 1'b1;  bus.pred_pc = 32'h120;
      bus.resolve = 1'b1;  bus.res_pc = 32'h120;
      bus.res_taken = 1'b1; bus.res_target = 32'h99;
      @(posedge clk);
      #1;
      bus.predict = 1'b0;  bus.resolve = 1'b0;  bus.EN = 1'b1;
      chk("en0_out_valid", W'(bus.out_valid), '0);
      pred(32'h120, 1'b0, 32'h124, 1'b0);

      // Fall-through wraps at the top of the address space
      pred(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0);

      // Asynchronous reset while a hit is presented
      res(32'h120, 1'b1, 32'h55);
      pred(32'h120, 1'b1, 32'h55, 1'b1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_out_valid", W'(bus.out_valid), '0);
      chk("async_rst_hit", W'(bus.HIT), '0);
      chk("async_rst_target", bus.TARGET, '0);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      pred(32'h120, 1'b0, 32'h124, 1'b0);

      @(posedge clk);
      @(posedge clk);
      #1 chk("queue_drained", W'(q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
